// File: rtl/psx_pad_responder.sv
// PSX/DualShock pad device emulator: answers host polls with ID, 0x5A, button and
// optional stick bytes, LSB first, pulsing ACK after every non-final byte.
module psx_pad_responder #(
   parameter int unsigned ANALOG    = 0,
   parameter int unsigned ACK_DELAY = 50,
   parameter int unsigned ACK_WIDTH = 50
) (
   input  logic        Clk,
   input  logic        reset,
   input  logic        I_psCLK,
   input  logic        I_psSEL,
   input  logic        I_psTXD,
   output logic        O_psRXD,
   output logic        O_psRXD_oe,
   output logic        O_psACK_n,
   input  logic [15:0] I_BTN,
   input  logic [31:0] I_STICK,
   output logic [7:0]  O_CMD,
   output logic        O_POLL_DONE,
   output logic        O_ERR
);

   localparam int unsigned ACK_MAX  = (ACK_DELAY > ACK_WIDTH) ? ACK_DELAY : ACK_WIDTH;
   localparam int unsigned ACK_CW   = $clog2(ACK_MAX + 1);
   localparam logic [3:0]  LAST_IDX = (ANALOG != 0) ? 4'd8 : 4'd4;
   localparam logic [7:0]  PAD_ID   = (ANALOG != 0) ? 8'h73 : 8'h41;

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_WAIT_END} state_e;
   typedef enum logic [1:0] {ACK_IDLE, ACK_WAIT, ACK_LOW} ack_e;

   logic [2:0]        clk_sync_q, sel_sync_q;
   logic [1:0]        txd_sync_q;
   logic              clk_fall, clk_rise, sel_fall, sel_rise, txd_s;

   state_e            state_q, state_d;
   logic [3:0]        byte_idx_q, byte_idx_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [7:0]        tx_sr_q, tx_sr_d;
   logic [7:0]        rx_sr_q, rx_sr_d;
   logic              rxd_q, rxd_d;
   logic              oe_q, oe_d;
   logic [7:0]        cmd_q, cmd_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [15:0]       btn_sh_q, btn_sh_d;
   logic [31:0]       stick_sh_q, stick_sh_d;
   logic              ack_arm;

   ack_e              ack_st_q, ack_st_d;
   logic [ACK_CW-1:0] ack_cnt_q, ack_cnt_d;
   logic              ack_n_q, ack_n_d;

   logic [7:0]        rx_next, next_byte, shadow_byte_c;
   logic              byte_fail;

   // Two synchroniser stages plus one edge-detect stage per host line
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         clk_sync_q <= 3'b111;
         sel_sync_q <= 3'b111;
         txd_sync_q <= 2'b11;
      end else begin
         clk_sync_q <= {clk_sync_q[1:0], I_psCLK};
         sel_sync_q <= {sel_sync_q[1:0], I_psSEL};
         txd_sync_q <= {txd_sync_q[0], I_psTXD};
      end
   end

   assign clk_fall = clk_sync_q[2] & ~clk_sync_q[1];
   assign clk_rise = ~clk_sync_q[2] & clk_sync_q[1];
   assign sel_fall = sel_sync_q[2] & ~sel_sync_q[1];
   assign sel_rise = ~sel_sync_q[2] & sel_sync_q[1];
   assign txd_s    = txd_sync_q[1];
   assign rx_next  = {txd_s, rx_sr_q[7:1]};

   // Byte that follows the one just completed, taken from the frame snapshot
   always_comb begin
      case (byte_idx_q)
         4'd3:    shadow_byte_c = btn_sh_q[15:8];
         4'd4:    shadow_byte_c = stick_sh_q[7:0];
         4'd5:    shadow_byte_c = stick_sh_q[15:8];
         4'd6:    shadow_byte_c = stick_sh_q[23:16];
         4'd7:    shadow_byte_c = stick_sh_q[31:24];
         default: shadow_byte_c = 8'hFF;
      endcase
   end

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         byte_idx_q <= '0;
         bit_cnt_q  <= '0;
         tx_sr_q    <= 8'hFF;
         rx_sr_q    <= '0;
         rxd_q      <= 1'b1;
         oe_q       <= 1'b0;
         cmd_q      <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         btn_sh_q   <= 16'hFFFF;
         stick_sh_q <= '0;
      end else begin
         state_q    <= state_d;
         byte_idx_q <= byte_idx_d;
         bit_cnt_q  <= bit_cnt_d;
         tx_sr_q    <= tx_sr_d;
         rx_sr_q    <= rx_sr_d;
         rxd_q      <= rxd_d;
         oe_q       <= oe_d;
         cmd_q      <= cmd_d;
         done_q     <= done_d;
         err_q      <= err_d;
         btn_sh_q   <= btn_sh_d;
         stick_sh_q <= stick_sh_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      byte_idx_d = byte_idx_q;
      bit_cnt_d  = bit_cnt_q;
      tx_sr_d    = tx_sr_q;
      rx_sr_d    = rx_sr_q;
      rxd_d      = rxd_q;
      oe_d       = oe_q;
      cmd_d      = cmd_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      btn_sh_d   = btn_sh_q;
      stick_sh_d = stick_sh_q;
      ack_arm    = 1'b0;
      byte_fail  = 1'b0;
      next_byte  = shadow_byte_c;

      case (state_q)
         ST_IDLE: begin
            if (sel_fall) begin
               state_d    = ST_SHIFT;
               byte_idx_d = '0;
               bit_cnt_d  = '0;
               tx_sr_d    = 8'hFF;
               oe_d       = 1'b1;
               rxd_d      = 1'b1;
            end
         end
         ST_SHIFT: begin
            // Bit 0 of each byte is presented before its first falling edge
            if (clk_fall && (bit_cnt_q != 3'd0)) begin
               tx_sr_d = {1'b1, tx_sr_q[7:1]};
               rxd_d   = tx_sr_q[1];
            end else if (clk_rise) begin
               rx_sr_d   = rx_next;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  case (byte_idx_q)
                     4'd0: begin
                        if (rx_next != 8'h01) byte_fail = 1'b1;
                        else                  next_byte = PAD_ID;
                     end
                     4'd1: begin
                        cmd_d = rx_next;
                        if (rx_next != 8'h42) byte_fail = 1'b1;
                        else                  next_byte = 8'h5A;
                     end
                     4'd2: begin
                        btn_sh_d   = I_BTN;
                        stick_sh_d = I_STICK;
                        next_byte  = I_BTN[7:0];
                     end
                     default: ;
                  endcase
                  if (byte_fail || (byte_idx_q == LAST_IDX)) begin
                     err_d   = byte_fail;
                     done_d  = ~byte_fail;
                     state_d = ST_WAIT_END;
                     oe_d    = 1'b0;
                     rxd_d   = 1'b1;
                  end else begin
                     ack_arm    = 1'b1;
                     tx_sr_d    = next_byte;
                     rxd_d      = next_byte[0];
                     byte_idx_d = (byte_idx_q == 4'hF) ? byte_idx_q : byte_idx_q + 4'd1;
                  end
               end
            end
         end
         ST_WAIT_END: begin
            oe_d  = 1'b0;
            rxd_d = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      // Deselect ends the transaction from any state, without a DONE/ERR pulse
      if (sel_rise && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
         oe_d    = 1'b0;
         rxd_d   = 1'b1;
         done_d  = 1'b0;
         err_d   = 1'b0;
         ack_arm = 1'b0;
      end
   end

   // ACK timer runs independently of the shift path; re-arming restarts the delay
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         ack_st_q  <= ACK_IDLE;
         ack_cnt_q <= '0;
         ack_n_q   <= 1'b1;
      end else begin
         ack_st_q  <= ack_st_d;
         ack_cnt_q <= ack_cnt_d;
         ack_n_q   <= ack_n_d;
      end
   end

   always_comb begin
      ack_st_d  = ack_st_q;
      ack_cnt_d = ack_cnt_q;
      if (sel_rise) begin
         ack_st_d  = ACK_IDLE;
         ack_cnt_d = '0;
      end else if (ack_arm) begin
         ack_st_d  = ACK_WAIT;
         ack_cnt_d = '0;
      end else begin
         case (ack_st_q)
            ACK_WAIT: begin
               if (ack_cnt_q == ACK_CW'(ACK_DELAY - 1)) begin
                  ack_st_d  = ACK_LOW;
                  ack_cnt_d = '0;
               end else begin
                  ack_cnt_d = ack_cnt_q + ACK_CW'(1);
               end
            end
            ACK_LOW: begin
               if (ack_cnt_q == ACK_CW'(ACK_WIDTH - 1)) begin
                  ack_st_d  = ACK_IDLE;
                  ack_cnt_d = '0;
               end else begin
                  ack_cnt_d = ack_cnt_q + ACK_CW'(1);
               end
            end
            default: ;
         endcase
      end
      ack_n_d = (ack_st_d != ACK_LOW);
   end

   assign O_psRXD     = rxd_q;
   assign O_psRXD_oe  = oe_q;
   assign O_psACK_n   = ack_n_q;
   assign O_CMD       = cmd_q;
   assign O_POLL_DONE = done_q;
   assign O_ERR       = err_q;

endmodule

// File: tb/tb_psx_pad_responder.sv
// Bench for psx_pad_responder: a host model polls a digital and an analog instance;
// a frame-level model predicts replies, a decoupled monitor pops and compares.
module tb_psx_pad_responder;

   localparam int AD   = 10;
   localparam int AW   = 6;
   localparam int H    = 6;
   localparam int GAP  = 12;
   localparam int TAIL = 30;

   logic        Clk   = 1'b0;
   logic        reset = 1'b1;
   logic        psclk = 1'b1;
   logic        pssel = 1'b1;
   logic        pstxd = 1'b1;
   logic [15:0] btn   = 16'hFFFF;
   logic [31:0] stick = 32'h0;
   logic [1:0]  rxd, oe, ackn, done, err;
   logic [7:0]  cmd [2];

   int cyc         = 0;
   int vectors     = 0;
   int miscompares = 0;

   logic [8:0] rxq  [2][$];
   logic [7:0] evq  [2][$];
   int         ackq [2][$];
   logic [7:0] exp_cmd [2];

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   psx_pad_responder #(.ANALOG(0), .ACK_DELAY(AD), .ACK_WIDTH(AW)) u_dig (
      .Clk(Clk), .reset(reset), .I_psCLK(psclk), .I_psSEL(pssel), .I_psTXD(pstxd),
      .O_psRXD(rxd[0]), .O_psRXD_oe(oe[0]), .O_psACK_n(ackn[0]),
      .I_BTN(btn), .I_STICK(stick), .O_CMD(cmd[0]),
      .O_POLL_DONE(done[0]), .O_ERR(err[0]));

   psx_pad_responder #(.ANALOG(1), .ACK_DELAY(AD), .ACK_WIDTH(AW)) u_ana (
      .Clk(Clk), .reset(reset), .I_psCLK(psclk), .I_psSEL(pssel), .I_psTXD(pstxd),
      .O_psRXD(rxd[1]), .O_psRXD_oe(oe[1]), .O_psACK_n(ackn[1]),
      .I_BTN(btn), .I_STICK(stick), .O_CMD(cmd[1]),
      .O_POLL_DONE(done[1]), .O_ERR(err[1]));

   task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", name, d, act, exp, cyc);
      end
   endtask

   task automatic chk_range(input string name, input int d, input int act, input int lo, input int hi);
      vectors++;
      if (act < lo || act > hi) begin
         miscompares++;
         $display("FAIL %s dut%0d: got %0d expected %0d..%0d", name, d, act, lo, hi);
      end
   endtask

   // Monitor: reassembles host-received bytes, watches DONE/ERR pulses and ACK timing
   initial begin : monitor
      logic       prev_clk;
      int         nbits;
      logic [7:0] sr [2];
      logic [1:0] prev_ack;
      int         lw [2];
      logic [8:0] e;
      prev_clk = 1'b1;
      nbits    = 0;
      prev_ack = 2'b11;
      lw[0] = 0; lw[1] = 0;
      sr[0] = '0; sr[1] = '0;
      forever begin
         @(negedge Clk);
         if (reset) begin
            nbits    = 0;
            prev_ack = 2'b11;
         end else begin
            if (pssel) nbits = 0;
            else if (psclk && !prev_clk) begin
               for (int d = 0; d < 2; d++) sr[d] = {rxd[d], sr[d][7:1]};
               nbits++;
               if (nbits == 8) begin
                  nbits = 0;
                  for (int d = 0; d < 2; d++) begin
                     if (rxq[d].size() == 0) chk("rx_unexpected_byte", d, 1, 0);
                     else begin
                        e = rxq[d].pop_front();
                        chk("rx_byte", d, sr[d], e[7:0]);
                        chk("rx_oe", d, oe[d], e[8]);
                     end
                  end
               end
            end
            for (int d = 0; d < 2; d++) begin
               if (done[d]) begin
                  if (evq[d].size() == 0) chk("done_unexpected", d, 1, 0);
                  else chk("done_event", d, evq[d].pop_front(), 8'h44);
               end
               if (err[d]) begin
                  if (evq[d].size() == 0) chk("err_unexpected", d, 1, 0);
                  else chk("err_event", d, evq[d].pop_front(), 8'h45);
               end
               if (prev_ack[d] && !ackn[d]) begin
                  lw[d] = 1;
                  if (ackq[d].size() == 0) chk("ack_unexpected", d, 1, 0);
                  else chk_range("ack_delay", d, cyc - ackq[d].pop_front(), AD + 2, AD + 4);
               end else if (!prev_ack[d] && !ackn[d]) begin
                  lw[d]++;
               end else if (!prev_ack[d] && ackn[d]) begin
                  chk("ack_width", d, lw[d], AW);
               end
            end
            prev_ack = ackn;
         end
         prev_clk = psclk;
      end
   end

   task automatic host_byte(input logic [7:0] b, input int nbits, output int rise_cyc);
      rise_cyc = 0;
      for (int i = 0; i < nbits; i++) begin
         @(posedge Clk); #1;
         psclk = 1'b0;
         pstxd = b[i];
         repeat (H) @(posedge Clk);
         #1;
         psclk    = 1'b1;
         rise_cyc = cyc;
         repeat (H - 1) @(posedge Clk);
      end
   endtask

   task automatic check_reset_vals();
      for (int d = 0; d < 2; d++) begin
         chk("rst_rxd", d, rxd[d], 1);
         chk("rst_oe", d, oe[d], 0);
         chk("rst_ack", d, ackn[d], 1);
         chk("rst_cmd", d, cmd[d], 0);
         chk("rst_done", d, done[d], 0);
         chk("rst_err", d, err[d], 0);
      end
   endtask

   task automatic end_checks();
      for (int d = 0; d < 2; d++) begin
         chk("idle_oe", d, oe[d], 0);
         chk("idle_rxd", d, rxd[d], 1);
         chk("idle_ack", d, ackn[d], 1);
         chk("cmd", d, cmd[d], exp_cmd[d]);
         chk("rx_missing", d, rxq[d].size(), 0);
         chk("event_missing", d, evq[d].size(), 0);
         chk("ack_missing", d, ackq[d].size(), 0);
      end
   endtask

   // One host transaction; expected replies are derived from the pad protocol rules
   task automatic run_frame(input logic [7:0] cmds [9], input int nfull, input int partial,
                            input bit chg, input logic [15:0] nbtn, input logic [31:0] nstk,
                            input bit do_rst);
      logic [7:0] fr [9];
      bit         ackx [2][9];
      int         n, endi, rc;
      bit         is_err;
      for (int d = 0; d < 2; d++) begin
         n  = (d != 0) ? 9 : 5;
         fr = '{8'hFF, (d != 0) ? 8'h73 : 8'h41, 8'h5A, btn[7:0], btn[15:8],
                stick[7:0], stick[15:8], stick[23:16], stick[31:24]};
         endi   = n - 1;
         is_err = 1'b0;
         if (cmds[0] != 8'h01)      begin endi = 0; is_err = 1'b1; end
         else if (cmds[1] != 8'h42) begin endi = 1; is_err = 1'b1; end
         for (int i = 0; i < 9; i++) begin
            ackx[d][i] = (i < endi) && (i < nfull);
            if (i < nfull) begin
               if (i <= endi) rxq[d].push_back({1'b1, fr[i]});
               else           rxq[d].push_back({1'b0, 8'hFF});
            end
         end
         if (endi < nfull) evq[d].push_back(is_err ? 8'h45 : 8'h44);
         if (nfull >= 2 && cmds[0] == 8'h01) exp_cmd[d] = cmds[1];
      end

      @(posedge Clk); #1;
      pssel = 1'b0;
      repeat (8) @(posedge Clk);
      for (int i = 0; i < nfull; i++) begin
         if (chg && i == 3) begin
            btn   = nbtn;
            stick = nstk;
         end
         host_byte(cmds[i], 8, rc);
         for (int d = 0; d < 2; d++) if (ackx[d][i]) ackq[d].push_back(rc);
         repeat (GAP) @(posedge Clk);
      end
      if (partial > 0) host_byte(cmds[nfull], partial, rc);

      if (do_rst) begin
         repeat (2) @(posedge Clk);
         #1 reset = 1'b1;
         @(negedge Clk);
         check_reset_vals();
         pssel = 1'b1;
         repeat (4) @(posedge Clk);
         #1 reset = 1'b0;
         exp_cmd[0] = 8'h00;
         exp_cmd[1] = 8'h00;
      end else begin
         repeat (TAIL) @(posedge Clk);
         #1 pssel = 1'b1;
         repeat (3) @(posedge Clk);
         @(negedge Clk);
         for (int d = 0; d < 2; d++) begin
            chk("desel_oe", d, oe[d], 0);
            chk("desel_ack", d, ackn[d], 1);
         end
      end
      repeat (20) @(posedge Clk);
      @(negedge Clk);
      end_checks();
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [7:0] c [9];
      int         typ, nf, pb;
      logic [15:0] nb;
      logic [31:0] ns;
      exp_cmd[0] = 8'h00;
      exp_cmd[1] = 8'h00;

      repeat (3) @(posedge Clk);
      @(negedge Clk);
      check_reset_vals();
      #1 reset = 1'b0;
      repeat (5) @(posedge Clk);

      btn   = 16'hFFFE;
      stick = 32'h80807F7F;
      c = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      run_frame(c, 5, 0, 0, 16'h0, 32'h0, 0);
      run_frame(c, 9, 0, 0, 16'h0, 32'h0, 0);

      c[0] = 8'h81;
      run_frame(c, 5, 0, 0, 16'h0, 32'h0, 0);
      c[0] = 8'h01; c[1] = 8'h43;
      run_frame(c, 9, 0, 0, 16'h0, 32'h0, 0);
      c[1] = 8'h42;

      run_frame(c, 2, 3, 0, 16'h0, 32'h0, 0);
      run_frame(c, 9, 0, 0, 16'h0, 32'h0, 0);

      btn = 16'hFFFE;
      run_frame(c, 9, 0, 1, 16'hFFFD, 32'h80807F7F, 0);
      run_frame(c, 9, 0, 0, 16'h0, 32'h0, 0);

      run_frame(c, 2, 4, 0, 16'h0, 32'h0, 1);
      run_frame(c, 9, 0, 0, 16'h0, 32'h0, 0);

      for (int k = 0; k < 14; k++) begin
         typ = $urandom_range(0, 4);
         c[0] = 8'h01;
         c[1] = 8'h42;
         for (int i = 2; i < 9; i++) c[i] = 8'($urandom);
         nf = 9;
         pb = 0;
         nb = 16'($urandom);
         ns = $urandom;
         if (typ != 4) begin
            btn   = 16'($urandom);
            stick = $urandom;
         end
         if (typ == 1) begin
            c[0] = 8'($urandom);
            if (c[0] == 8'h01) c[0] = 8'h81;
         end else if (typ == 2) begin
            c[1] = 8'($urandom);
            if (c[1] == 8'h42) c[1] = 8'h43;
         end else if (typ == 3) begin
            nf = $urandom_range(0, 7);
            pb = $urandom_range(1, 7);
         end
         run_frame(c, nf, pb, typ == 4, nb, ns, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
